// File: rtl/guess_pkg.sv
// Shared definitions for the guess checker: FSM encoding, verdict codes,
// LFSR constants and a BCD folding helper.
package guess_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP2,
    S_CMP1,
    S_CMP0,
    S_DONE
  } state_t;

  localparam logic [7:0] RES_NONE = 8'h00;
  localparam logic [7:0] RES_LT   = 8'h10;
  localparam logic [7:0] RES_EQ   = 8'h20;
  localparam logic [7:0] RES_GT   = 8'h40;
  localparam logic [7:0] RES_INV  = 8'h80;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] fold_digit(input logic [3:0] n);
    return (n >= 4'd10) ? n - 4'd10 : n;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; nonzero seed keeps it out of the lock-up state.
module lfsr16
  import guess_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) value <= LFSR_SEED;
    else     value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/guess_checker.sv
// Compares a 3-digit BCD guess against an LFSR-derived target, MSD first,
// and reports a one-hot verdict with a one-cycle done pulse.
module guess_checker
  import guess_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        generate_random,
  input  logic        check_start,
  input  logic [11:0] guess,
  output logic [7:0]  check_result,
  output logic        check_done,
  output logic        busy,
  output logic [11:0] target,
  output logic [3:0]  attempts
);

  state_t      state;
  logic [15:0] rnd;
  logic        start_q;
  logic [11:0] guess_q;
  logic [7:0]  verdict;
  logic        start_edge;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (rnd)
  );

  assign start_edge = check_start & ~start_q;
  assign busy       = (state != S_IDLE);

  function automatic logic digits_ok(input logic [11:0] g);
    return (g[11:8] <= 4'd9) && (g[7:4] <= 4'd9) && (g[3:0] <= 4'd9);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      guess_q      <= '0;
      verdict      <= RES_NONE;
      check_result <= RES_NONE;
      check_done   <= 1'b0;
      target       <= '0;
      attempts     <= '0;
    end else begin
      check_done <= 1'b0;
      start_q    <= check_start;
      // A target load aborts any comparison and swallows a coincident start
      if (generate_random) begin
        target       <= {fold_digit(rnd[11:8]), fold_digit(rnd[7:4]), fold_digit(rnd[3:0])};
        attempts     <= '0;
        check_result <= RES_NONE;
        state        <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start_edge) begin
            guess_q      <= guess;
            check_result <= RES_NONE;
            if (attempts != 4'd15) attempts <= attempts + 4'd1;
            state        <= S_CMP2;
          end
          S_CMP2: begin
            if (!digits_ok(guess_q)) begin
              verdict <= RES_INV;
              state   <= S_DONE;
            end else if (guess_q[11:8] != target[11:8]) begin
              verdict <= (guess_q[11:8] < target[11:8]) ? RES_LT : RES_GT;
              state   <= S_DONE;
            end else begin
              state   <= S_CMP1;
            end
          end
          S_CMP1: begin
            if (guess_q[7:4] != target[7:4]) begin
              verdict <= (guess_q[7:4] < target[7:4]) ? RES_LT : RES_GT;
              state   <= S_DONE;
            end else begin
              state   <= S_CMP0;
            end
          end
          S_CMP0: begin
            if (guess_q[3:0] != target[3:0])
              verdict <= (guess_q[3:0] < target[3:0]) ? RES_LT : RES_GT;
            else
              verdict <= RES_EQ;
            state <= S_DONE;
          end
          S_DONE: begin
            check_result <= verdict;
            check_done   <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with an independent LFSR reference for targets.
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        generate_random;
  logic        check_start;
  logic [11:0] guess;
  logic [7:0]  check_result;
  logic        check_done;
  logic        busy;
  logic [11:0] target;
  logic [3:0]  attempts;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] ref_lfsr;
  logic [3:0]  exp_att;
  logic [11:0] exp_t;

  guess_checker dut (
    .clk             (clk),
    .rst             (rst),
    .generate_random (generate_random),
    .check_start     (check_start),
    .guess           (guess),
    .check_result    (check_result),
    .check_done      (check_done),
    .busy            (busy),
    .target          (target),
    .attempts        (attempts)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11, seed ACE1, shifting left
  always @(posedge clk) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  function automatic logic [3:0] fold(input logic [3:0] n);
    return (n > 4'd9) ? n - 4'd10 : n;
  endfunction

  function automatic logic [11:0] map_t(input logic [15:0] v);
    return {fold(v[11:8]), fold(v[7:4]), fold(v[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic inc_sat(input logic [3:0] a);
    return a != 4'd15;
  endfunction

  // Rising edge of check_start, then count cycles to check_done
  task automatic run_check(input string tag, input logic [11:0] g, input logic [7:0] res, input int lat);
    int n;
    logic seen;
    seen = 1'b0;
    n = 0;
    guess = g;
    check_start = 1'b1;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      check_start = 1'b0;
      if (check_done) begin seen = 1'b1; n = i - 1; end
    end
    if (inc_sat(exp_att)) exp_att = exp_att + 4'd1;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_result"}, check_result, res);
    chk({tag, "_attempts"}, attempts, exp_att);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, check_done}, 32'd0);
  endtask

  // Pulse generate_random on the cycle the reference LFSR maps to the wanted target
  task automatic load_target(input logic [11:0] want);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      if (map_t(ref_lfsr) == want) begin
        hit = 1'b1;
        generate_random = 1'b1;
        @(negedge clk);
        generate_random = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    exp_att = 4'd0;
    chk("load_hit", {31'd0, hit}, 32'd1);
    chk("load_target", target, want);
    chk("load_result", check_result, 8'h00);
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    generate_random = 1'b0;
    check_start = 1'b0;
    guess = 12'h000;
    exp_att = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", check_result, 8'h00);
    chk("rst_done", {31'd0, check_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_target", target, 12'h000);
    chk("rst_attempts", attempts, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: random target, exact guess
    exp_t = map_t(ref_lfsr);
    generate_random = 1'b1;
    @(negedge clk);
    generate_random = 1'b0;
    chk("s1_target", target, exp_t);
    run_check("s1_eq", exp_t, 8'h20, 4);

    // 2: fixed target 537, decisions at each digit
    load_target(12'h537);
    run_check("s2_lt_d2", 12'h412, 8'h10, 2);
    run_check("s2_gt_d1", 12'h582, 8'h40, 3);
    run_check("s2_gt_d0", 12'h539, 8'h40, 4);
    run_check("s2_lt_d0", 12'h530, 8'h10, 4);

    // 3: invalid digit
    run_check("s3_inv", 12'h5A7, 8'h80, 2);

    // 4: second edge while busy is dropped
    guess = 12'h539;
    dn = 0;
    check_start = 1'b1;
    @(negedge clk); check_start = 1'b0; dn += check_done;
    @(negedge clk); check_start = 1'b1; dn += check_done;
    chk("s4_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); check_start = 1'b0; dn += check_done;
    end
    if (inc_sat(exp_att)) exp_att = exp_att + 4'd1;
    chk("s4_done_count", dn, 1);
    chk("s4_attempts", attempts, exp_att);
    chk("s4_result", check_result, 8'h40);

    // 5: reload during CMP1 aborts
    guess = 12'h582;
    check_start = 1'b1;
    @(negedge clk); check_start = 1'b0;
    @(negedge clk);
    exp_t = map_t(ref_lfsr);
    generate_random = 1'b1;
    @(negedge clk);
    generate_random = 1'b0;
    exp_att = 4'd0;
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s5_result", check_result, 8'h00);
    chk("s5_attempts", attempts, 4'd0);
    chk("s5_target", target, exp_t);
    dn = check_done;
    repeat (6) begin @(negedge clk); dn += check_done; end
    chk("s5_no_done", dn, 0);

    // 6: attempts saturate
    for (int i = 0; i < 17; i++) run_check("s6_eq", exp_t, 8'h20, 4);
    chk("s6_sat", attempts, 4'd15);

    // 7: reset in CMP2
    guess = 12'h123;
    check_start = 1'b1;
    @(negedge clk);
    chk("s7_in_cmp", {31'd0, busy}, 32'd1);
    check_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_att = 4'd0;
    chk("s7_result", check_result, 8'h00);
    chk("s7_done", {31'd0, check_done}, 32'd0);
    chk("s7_busy", {31'd0, busy}, 32'd0);
    chk("s7_target", target, 12'h000);
    chk("s7_attempts", attempts, 4'd0);
    dn = 0;
    repeat (5) begin @(negedge clk); dn += check_done; end
    chk("s7_no_done", dn, 0);

    // 8: continuous reloads stay BCD and track the reference sequence
    generate_random = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      exp_t = map_t(ref_lfsr);
      @(negedge clk);
      chk("s8_bcd", {31'd0, (target[11:8] <= 4'd9) && (target[7:4] <= 4'd9) && (target[3:0] <= 4'd9)}, 32'd1);
      chk("s8_target", target, exp_t);
    end
    generate_random = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
